hs_cdc_tag_unpack: RTL and testbench
====================================

# hs_cdc_tag_unpack

Destination-domain consumer placed directly after the 2-phase multi-bit CDC stage. It samples the packed `{tag, payload}` word leaving the CDC, detects each new item by a change of the sequence tag, and pushes the payload into a small first-word-fall-through FIFO presented as a valid/ready stream. This turns the level-held CDC output into discrete, flow-controlled transfers. It also flags overflow and, optionally, counts tag gaps, which mark items the source overwrote before they crossed.

## Interface
- `DATA_W`, 32: payload width.
- `TAG_W`, 2: sequence tag width, 1-8; the tag occupies the MSBs of `in_word`.
- `DEPTH`, 4: FIFO entries, power of 2, 2-16.
- `CNT_W`, 16: statistics counter width.

- `clk`  in  1  sole clock; the destination clock of the upstream CDC stage.
- `sreset`  in  1  reset, synchronous, active-high.
- `in_word`  in  TAG_W+DATA_W  packed CDC output, `{tag, payload}`, synchronous to `clk`.
- `m_valid`  out  1  FIFO head valid.
- `m_ready`  in  1  downstream accepts head.
- `m_data`  out  DATA_W  head payload; 0 whenever `m_valid`=0.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; an item was dropped because the FIFO was full.
- `clear_stat`  in  1  one-cycle pulse; clears `overflow`, `gap_cnt` and `ovf_cnt`.
- `gap_cnt`  out  CNT_W  number of skipped tags, saturating.
- `ovf_cnt`  out  CNT_W  number of dropped items, saturating.

## Operation
- Input register: `in_q <= in_word` every cycle. All detection logic uses `in_q` only.
- Tag tracker `last_tag` resets to 0, matching the CDC reset value of 0. After reset the source issues its first tag as 1 and increments the tag modulo 2^TAG_W for each item.
- Event: `in_q.tag != last_tag`. On an event, `last_tag <= in_q.tag` unconditionally, so the same item is never pushed twice.
- Push on event when `level < DEPTH`, or when `level == DEPTH` and a pop occurs in the same cycle (`m_valid && m_ready`).
- Drop: event, FIFO full, and no pop in the same cycle. The payload is discarded, `overflow` is set, and `ovf_cnt` increments.
- Gap: `d = (in_q.tag - last_tag) mod 2^TAG_W`. If `d > 1`, then `gap_cnt += d-1`, saturating at all-ones. With `TAG_W=1`, `d` is always 1 and `gap_cnt` stays 0.
- FIFO:
  - Circular buffer with read/write pointers of `$clog2(DEPTH)` bits that wrap naturally.
  - `level` changes by +1 on push only, -1 on pop only, and 0 on push+pop.
  - Storage is not reset. Pointers and level are reset.
- Pop: `m_valid && m_ready`. A pop with `m_valid`=0 is ignored; `level` never underflows.
- `clear_stat` takes priority over a same-cycle set or increment. After the clear cycle, the flag and counters read 0.
- `sreset` mid-operation: the FIFO is emptied, `last_tag`=0, `in_q`=0, and the flag and counters are 0. The first event can occur 2 cycles after `sreset` deasserts.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `level`=0, `overflow`=0, `gap_cnt`=0, `ovf_cnt`=0.
- Latency: a new tag on `in_word` in cycle N appears in `in_q` in N+1, is pushed at the end of N+1, and gives `m_valid`=1 with the payload in N+2 (FIFO previously empty).
- Throughput: one event per cycle is accepted. The upstream CDC delivers far slower than this, so steady-state drops indicate a stalled consumer.
- `m_data` and `m_valid` are registered/flop-derived with no combinational path from `in_word`. `m_ready` is the only input-to-output combinational dependency, and it goes into the pop logic only.
- Overflow and counter updates are visible the cycle after the event is detected in `in_q`.

## Configuration
- `HS_CDC_TAG_UNPACK_STAT_EN` defined: `gap_cnt` and `ovf_cnt` are implemented as described.
- Not defined:
  - `gap_cnt` and `ovf_cnt` are tied to 0 and the gap subtractor is not built.
  - `overflow` and `clear_stat` still behave as specified.

## Test plan
- Reset then `in_word={2'd1,32'hA5A5_0001}` in cycle 0 -> `m_valid`=1, `m_data`=32'hA5A5_0001 in cycle 2; `level`=1. Pop -> `level`=0, `m_data`=0.
- Tags 1,2,3,0,1 on consecutive changes with `m_ready`=0, `DEPTH`=4 -> 4 entries stored, 5th dropped; `overflow`=1, `ovf_cnt`=1; draining returns the first four payloads in order.
- FIFO full, `m_ready`=1 in the same cycle an event is detected -> push accepted, no drop, `level` stays 4.
- Tag jumps 1 -> 3 with STAT_EN -> `gap_cnt`=1; then 3 -> 2 -> `gap_cnt`=1+2=3. Without STAT_EN -> `gap_cnt`=0.
- `in_word` held constant for 100 cycles after one event -> exactly one push.
- `clear_stat` in the same cycle as a drop -> `overflow`=0 and `ovf_cnt`=0 afterwards. `sreset` with `level`=3 -> `level`=0, `m_valid`=0 next cycle.

Source files
------------

// File: rtl/hs_cdc_tag_unpack.sv
// rtl/hs_cdc_tag_unpack.sv - tag-change detector pushing CDC payloads into a FWFT valid/ready FIFO
// Optional statistics counters (gap_cnt, ovf_cnt) are built when HS_CDC_TAG_UNPACK_STAT_EN is defined.
module hs_cdc_tag_unpack #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       sreset,
    input  logic [TAG_W+DATA_W-1:0]    in_word,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clear_stat,
    output logic [CNT_W-1:0]           gap_cnt,
    output logic [CNT_W-1:0]           ovf_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TAG_W+DATA_W-1:0] in_q;
    logic [TAG_W-1:0]        last_tag_q;
    logic [TAG_W-1:0]        in_tag;
    logic [DATA_W-1:0]       in_pay;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [LW-1:0]           level_q;
    logic [LW-1:0]           level_d;
    logic                    overflow_q;
    logic                    tag_event;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;

    assign in_tag    = in_q[TAG_W+DATA_W-1 -: TAG_W];
    assign in_pay    = in_q[DATA_W-1:0];
    assign tag_event = (in_tag != last_tag_q);
    assign full      = (level_q == LW'(DEPTH));
    assign m_valid   = (level_q != '0);
    assign pop       = m_valid && m_ready;
    // A full FIFO can still take the new item if the head leaves this cycle.
    assign push      = tag_event && (!full || pop);
    assign drop      = tag_event && full && !pop;

    assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            in_q       <= '0;
            last_tag_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            in_q <= in_word;
            if (tag_event) begin
                last_tag_q <= in_tag;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            if (clear_stat) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_pay;
        end
    end

`ifdef HS_CDC_TAG_UNPACK_STAT_EN
    logic [CNT_W-1:0] gap_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [TAG_W-1:0] tag_diff;
    logic [TAG_W-1:0] gap_add;
    logic [CNT_W:0]   gap_sum;

    // Modular distance between tags; anything above 1 means items were overwritten upstream.
    assign tag_diff = in_tag - last_tag_q;
    assign gap_add  = tag_diff - TAG_W'(1);
    assign gap_sum  = {1'b0, gap_cnt_q} + (CNT_W+1)'(gap_add);

    always_ff @(posedge clk) begin
        if (sreset || clear_stat) begin
            gap_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            if (tag_event && (tag_diff > TAG_W'(1))) begin
                gap_cnt_q <= gap_sum[CNT_W] ? '1 : gap_sum[CNT_W-1:0];
            end
            if (drop && !(&ovf_cnt_q)) begin
                ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
            end
        end
    end

    assign gap_cnt = gap_cnt_q;
    assign ovf_cnt = ovf_cnt_q;
`else
    assign gap_cnt = '0;
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_hs_cdc_tag_unpack.sv
// tb/tb_hs_cdc_tag_unpack.sv - directed self-checking bench for hs_cdc_tag_unpack
module tb_hs_cdc_tag_unpack;
`ifdef HS_CDC_TAG_UNPACK_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk;
    logic        sreset;
    logic [33:0] in_word;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  level;
    logic        overflow;
    logic        clear_stat;
    logic [15:0] gap_cnt;
    logic [15:0] ovf_cnt;

    int total_cnt = 0;
    int pass_cnt  = 0;

    hs_cdc_tag_unpack #(.DATA_W(32), .TAG_W(2), .DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .sreset     (sreset),
        .in_word    (in_word),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level),
        .overflow   (overflow),
        .clear_stat (clear_stat),
        .gap_cnt    (gap_cnt),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] p);
        in_word = {t, p};
        tick();
    endtask

    task automatic do_reset();
        sreset     = 1'b1;
        in_word    = '0;
        m_ready    = 1'b0;
        clear_stat = 1'b0;
        tick();
        tick();
        sreset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({m_valid, m_data, level, overflow} !== 37'd0)
            $display("FAIL reset_outputs: got v=%0d d=%0h l=%0d o=%0d expected all 0", m_valid, m_data, level, overflow);
        else pass_cnt++;
        total_cnt++;
        if ({gap_cnt, ovf_cnt} !== 32'd0)
            $display("FAIL reset_counters: got gap=%0d ovf=%0d expected 0 0", gap_cnt, ovf_cnt);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        do_reset();
        in_word = {2'd1, 32'hA5A5_0001};
        tick();
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL latency_early_valid: got %0d expected 0", m_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001)
            $display("FAIL latency_head: got v=%0d d=%0h expected v=1 d=a5a50001", m_valid, m_data);
        else pass_cnt++;
        total_cnt++;
        if (level !== 3'd1) $display("FAIL latency_level: got %0d expected 1", level);
        else pass_cnt++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total_cnt++;
        if (level !== 3'd0 || m_valid !== 1'b0 || m_data !== 32'd0)
            $display("FAIL latency_pop: got l=%0d v=%0d d=%0h expected 0 0 0", level, m_valid, m_data);
        else pass_cnt++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total_cnt++;
        if (level !== 3'd0) $display("FAIL pop_empty_underflow: got %0d expected 0", level);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        do_reset();
        in_word = {2'd1, 32'h0000_BEEF};
        for (int i = 0; i < 100; i++) tick();
        total_cnt++;
        if (level !== 3'd1 || m_data !== 32'h0000_BEEF)
            $display("FAIL hold_single_push: got l=%0d d=%0h expected 1 beef", level, m_data);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_q [4];
        exp_q[0] = 32'h0000_0010;
        exp_q[1] = 32'h0000_0011;
        exp_q[2] = 32'h0000_0012;
        exp_q[3] = 32'h0000_0013;
        do_reset();
        send(2'd1, 32'h0000_0010);
        send(2'd2, 32'h0000_0011);
        send(2'd3, 32'h0000_0012);
        send(2'd0, 32'h0000_0013);
        send(2'd1, 32'h0000_0014);
        tick();
        tick();
        total_cnt++;
        if (level !== 3'd4) $display("FAIL ovf_level: got %0d expected 4", level);
        else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0d expected 1", overflow);
        else pass_cnt++;
        total_cnt++;
        if (ovf_cnt !== (STAT ? 16'd1 : 16'd0) || gap_cnt !== 16'd0)
            $display("FAIL ovf_counters: got ovf=%0d gap=%0d expected ovf=%0d gap=0", ovf_cnt, gap_cnt, STAT ? 1 : 0);
        else pass_cnt++;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== exp_q[i])
                $display("FAIL ovf_drain_%0d: got v=%0d d=%0h expected v=1 d=%0h", i, m_valid, m_data, exp_q[i]);
            else pass_cnt++;
            tick();
        end
        m_ready = 1'b0;
        total_cnt++;
        if (level !== 3'd0 || m_valid !== 1'b0)
            $display("FAIL ovf_drained: got l=%0d v=%0d expected 0 0", level, m_valid);
        else pass_cnt++;
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_q [4];
        exp_q[0] = 32'h0000_0022;
        exp_q[1] = 32'h0000_0023;
        exp_q[2] = 32'h0000_0020;
        exp_q[3] = 32'h0000_0055;
        do_reset();
        send(2'd1, 32'h0000_0021);
        send(2'd2, 32'h0000_0022);
        send(2'd3, 32'h0000_0023);
        send(2'd0, 32'h0000_0020);
        tick();
        in_word = {2'd1, 32'h0000_0055};
        tick();
        total_cnt++;
        if (level !== 3'd4 || m_data !== 32'h0000_0021)
            $display("FAIL full_pre: got l=%0d d=%0h expected 4 21", level, m_data);
        else pass_cnt++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total_cnt++;
        if (level !== 3'd4 || overflow !== 1'b0 || ovf_cnt !== 16'd0)
            $display("FAIL full_push_pop: got l=%0d o=%0d ovf=%0d expected 4 0 0", level, overflow, ovf_cnt);
        else pass_cnt++;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (m_data !== exp_q[i])
                $display("FAIL full_drain_%0d: got %0h expected %0h", i, m_data, exp_q[i]);
            else pass_cnt++;
            tick();
        end
        m_ready = 1'b0;
    endtask

    task automatic test_gap_and_sreset();
        do_reset();
        send(2'd1, 32'h0000_0031);
        send(2'd3, 32'h0000_0033);
        tick();
        tick();
        total_cnt++;
        if (gap_cnt !== (STAT ? 16'd1 : 16'd0))
            $display("FAIL gap_1_to_3: got %0d expected %0d", gap_cnt, STAT ? 1 : 0);
        else pass_cnt++;
        send(2'd2, 32'h0000_0032);
        tick();
        tick();
        total_cnt++;
        if (gap_cnt !== (STAT ? 16'd3 : 16'd0))
            $display("FAIL gap_3_to_2: got %0d expected %0d", gap_cnt, STAT ? 3 : 0);
        else pass_cnt++;
        total_cnt++;
        if (level !== 3'd3) $display("FAIL gap_level: got %0d expected 3", level);
        else pass_cnt++;
        sreset  = 1'b1;
        in_word = '0;
        tick();
        sreset = 1'b0;
        total_cnt++;
        if (level !== 3'd0 || m_valid !== 1'b0 || m_data !== 32'd0 || gap_cnt !== 16'd0)
            $display("FAIL sreset_mid: got l=%0d v=%0d d=%0h gap=%0d expected all 0", level, m_valid, m_data, gap_cnt);
        else pass_cnt++;
    endtask

    task automatic test_clear_drop();
        do_reset();
        send(2'd1, 32'h0000_0041);
        send(2'd2, 32'h0000_0042);
        send(2'd3, 32'h0000_0043);
        send(2'd0, 32'h0000_0040);
        send(2'd1, 32'h0000_0045);
        tick();
        total_cnt++;
        if (overflow !== 1'b1 || ovf_cnt !== (STAT ? 16'd1 : 16'd0))
            $display("FAIL clear_pre: got o=%0d ovf=%0d expected 1 %0d", overflow, ovf_cnt, STAT ? 1 : 0);
        else pass_cnt++;
        in_word = {2'd2, 32'h0000_0046};
        tick();
        clear_stat = 1'b1;
        tick();
        clear_stat = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0 || ovf_cnt !== 16'd0)
            $display("FAIL clear_with_drop: got o=%0d ovf=%0d expected 0 0", overflow, ovf_cnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (overflow !== 1'b0 || level !== 3'd4 || m_data !== 32'h0000_0041)
            $display("FAIL clear_after: got o=%0d l=%0d d=%0h expected 0 4 41", overflow, level, m_data);
        else pass_cnt++;
    endtask

    initial begin
        sreset     = 1'b1;
        in_word    = '0;
        m_ready    = 1'b0;
        clear_stat = 1'b0;
        test_reset();
        test_latency();
        test_hold();
        test_overflow();
        test_full_pop();
        test_gap_and_sreset();
        test_clear_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
